// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 VGA path and the pixel
//   sources that feed it.
//   - H_/V_ region widths (sync, back porch, visible, front porch) and the
//     derived totals and first-visible counter positions.
//   - Default sync polarity and default pixel-source latency.
//   - RGB565 colour constants used by the pixel generators.
//   - in_span(): half-open window test on a 10-bit counter. It compares
//     with one extra bit so that a window may end exactly at 1024.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;   // 800

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;   // 525

  // Counter value of the first visible column / row.
  localparam int H_VIS_START = H_SYNC + H_BACK;                   // 144
  localparam int V_VIS_START = V_SYNC + V_BACK;                   // 35

  localparam int CNT_W = 10;

  // 0 = active-low sync pulses (standard for 640x480@60).
  localparam bit SYNC_POL = 1'b0;

  // Latency of a registered pixel source.
  localparam int PIX_LAT     = 1;
  localparam int PIX_LAT_MAX = 4;

  // pix_x / pix_y value presented outside the visible area.
  localparam logic [CNT_W-1:0] PIX_NONE = 10'h3FF;

  // RGB565 colours.
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  // True when beg <= cnt < lim.
  function automatic logic in_span(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W:0]   beg,
                                   input logic [CNT_W:0]   lim);
    logic [CNT_W:0] c;
    c = {1'b0, cnt};
    return (c >= beg) && (c < lim);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
//   Fixed-length shift register used to line the sync/visible flags up with
//   the pixel data that arrives from the pixel source some cycles after
//   pix_x/pix_y were presented.
//   Parameters:
//     WIDTH   - bits per stage
//     DEPTH   - number of register stages; 0 gives a plain wire
//     RST_VAL - value loaded into every stage on reset
//   Ports:
//     clk    in  1      clock
//     rst_n  in  1      asynchronous active-low reset
//     d_i    in  WIDTH  data into the first stage
//     q_o    out WIDTH  data out of the last stage (d_i when DEPTH=0)
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // No stages: clock and reset are not needed here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_d;

      if (gi == 0) begin : g_head
        assign stage_d = d_i;
      end else begin : g_tail
        assign stage_d = stage_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q[gi] <= RST_VAL;
        end else begin
          stage_q[gi] <= stage_d;
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_ctrl.sv
// ---------------------------------------------------------------------------
// vga_ctrl
//   VGA timing controller. Runs the horizontal/vertical counters, presents
//   the visible pixel coordinate to the pixel sources, takes their RGB565
//   answer PIX_LAT cycles later and drives sync and colour to the DAC.
//   Counter-to-pin latency is PIX_LAT+1 for both sync and rgb, so the
//   syncs stay aligned with the pixels they frame.
//   Ports:
//     vga_clk    in   1   pixel clock (25 MHz for 640x480@60)
//     sys_rst_n  in   1   asynchronous active-low reset
//     pix_data   in   16  RGB565 from pixel source, PIX_LAT cycles after pix_x/pix_y
//     pix_x      out  10  visible column, 10'h3FF outside the visible area
//     pix_y      out  10  visible row,    10'h3FF outside the visible area
//     frame_end  out  1   high on the last cycle of each frame
//     hsync      out  1   horizontal sync (active level SYNC_POL)
//     vsync      out  1   vertical sync   (active level SYNC_POL)
//     rgb        out  16  RGB565 to DAC, 0 during blanking
// ---------------------------------------------------------------------------
module vga_ctrl #(
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BACK   = vga_timing_pkg::H_BACK,
  parameter int H_VALID  = vga_timing_pkg::H_VALID,
  parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BACK   = vga_timing_pkg::V_BACK,
  parameter int V_VALID  = vga_timing_pkg::V_VALID,
  parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL,
  parameter int PIX_LAT  = vga_timing_pkg::PIX_LAT
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_end,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
);

  import vga_timing_pkg::*;

  // Derived timing for this instance's parameter set.
  localparam int HTOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int VTOT = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HVS  = H_SYNC + H_BACK;
  localparam int VVS  = V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_N = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_N = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_OFS    = CNT_W'(HVS);
  localparam logic [CNT_W-1:0] V_OFS    = CNT_W'(VVS);

  // Visible windows, one bit wider so an edge at 1024 is representable.
  localparam logic [CNT_W:0] H_VIS_BEG = (CNT_W+1)'(HVS);
  localparam logic [CNT_W:0] H_VIS_END = (CNT_W+1)'(HVS + H_VALID);
  localparam logic [CNT_W:0] V_VIS_BEG = (CNT_W+1)'(VVS);
  localparam logic [CNT_W:0] V_VIS_END = (CNT_W+1)'(VVS + V_VALID);

  // Delay-line word: {hs, vs, vis}. Reset holds syncs inactive, vis low.
  localparam int               DL_W   = 3;
  localparam logic [DL_W-1:0]  DL_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (HTOT > (1 << CNT_W) || VTOT > (1 << CNT_W)) begin : g_bad_totals
    $error("vga_ctrl: H/V totals must not exceed 1024");
  end

  if (HTOT < 1 || VTOT < 1) begin : g_bad_empty
    $error("vga_ctrl: H/V totals must be non-zero");
  end

  if (PIX_LAT < 0 || PIX_LAT > PIX_LAT_MAX) begin : g_bad_lat
    $error("vga_ctrl: PIX_LAT must be in 0..4");
  end

  // -------------------------------------------------------------------------
  // Counters
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] cnt_v_q, cnt_v_d;
  logic             h_wrap;
  logic             v_wrap;

  assign h_wrap = (cnt_h_q == H_LAST);
  assign v_wrap = (cnt_v_q == V_LAST);

  always_comb begin
    cnt_h_d = h_wrap ? '0 : cnt_h_q + 1'b1;
    cnt_v_d = cnt_v_q;
    // The line counter only moves on the last column of a line.
    if (h_wrap) begin
      cnt_v_d = v_wrap ? '0 : cnt_v_q + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // -------------------------------------------------------------------------
  // Decode of the registered counters (combinational)
  // -------------------------------------------------------------------------
  logic vis_h;
  logic vis_v;
  logic vis;
  logic hs_raw;
  logic vs_raw;

  assign vis_h = in_span(cnt_h_q, H_VIS_BEG, H_VIS_END);
  assign vis_v = in_span(cnt_v_q, V_VIS_BEG, V_VIS_END);
  assign vis   = vis_h && vis_v;

  assign hs_raw = (cnt_h_q < H_SYNC_N) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = (cnt_v_q < V_SYNC_N) ? SYNC_POL : ~SYNC_POL;

  // Coordinates go to the pixel sources straight from the counters so that
  // the source's own pipeline starts as early as possible.
  assign pix_x = vis ? (cnt_h_q - H_OFS) : PIX_NONE;
  assign pix_y = vis ? (cnt_v_q - V_OFS) : PIX_NONE;

  assign frame_end = h_wrap && v_wrap;

  // -------------------------------------------------------------------------
  // Align sync/visible flags with the pixel source's latency
  // -------------------------------------------------------------------------
  logic [DL_W-1:0] dl_in;
  logic [DL_W-1:0] dl_out;
  logic            hs_dly;
  logic            vs_dly;
  logic            vis_dly;

  assign dl_in = {hs_raw, vs_raw, vis};

  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (PIX_LAT),
    .RST_VAL (DL_RST)
  ) u_align (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .d_i   (dl_in),
    .q_o   (dl_out)
  );

  assign {hs_dly, vs_dly, vis_dly} = dl_out;

  // -------------------------------------------------------------------------
  // Output register stage (drives the DAC pins)
  // -------------------------------------------------------------------------
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [15:0] rgb_q,   rgb_d;

  always_comb begin
    hsync_d = hs_dly;
    vsync_d = vs_dly;
    // Whatever the source drives outside the visible area is discarded.
    rgb_d   = vis_dly ? pix_data : BLACK;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      rgb_q   <= BLACK;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_ctrl
//   Four controllers share clock and reset:
//     u_big : default 640x480 timing, PIX_LAT=1
//     u_s0  : reduced 17x12 timing, PIX_LAT=0
//     u_s1  : reduced 17x12 timing, PIX_LAT=1
//     u_s3  : reduced 17x12 timing, PIX_LAT=3, active-high syncs
//   Each has a pixel source answering {pix_x[5:0], pix_y} after its PIX_LAT.
//   A timeline model predicts every output from the number of cycles since
//   reset release; pulse widths/periods and a few literal pixels pin it.
// ---------------------------------------------------------------------------
module tb_vga_ctrl;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fe;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } obs_t;

  // Reduced timing for the small instances.
  localparam int SH_S = 4, SH_B = 3, SH_V = 8, SH_F = 2;   // 17 cycles/line
  localparam int SV_S = 2, SV_B = 3, SV_V = 5, SV_F = 2;   // 12 lines/frame
  localparam int S_HT = SH_S + SH_B + SH_V + SH_F;
  localparam int S_FRAME = S_HT * (SV_S + SV_B + SV_V + SV_F);   // 204

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  int t;          // cycles since reset release (0 while in reset)
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  function automatic logic [15:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {x[5:0], y};
  endfunction

  // ---------------- DUTs and their pixel sources ----------------
  logic [9:0]  px_b, py_b, px_0, py_0, px_1, py_1, px_3, py_3;
  logic        fe_b, hs_b, vs_b, fe_0, hs_0, vs_0, fe_1, hs_1, vs_1, fe_3, hs_3, vs_3;
  logic [15:0] rgb_b, rgb_0, rgb_1, rgb_3;
  logic [15:0] pd_b, pd_0, pd_1, pd_3, p3a, p3b;

  always @(posedge clk) pd_b <= pat(px_b, py_b);
  assign pd_0 = pat(px_0, py_0);
  always @(posedge clk) pd_1 <= pat(px_1, py_1);
  always @(posedge clk) begin
    p3a  <= pat(px_3, py_3);
    p3b  <= p3a;
    pd_3 <= p3b;
  end

  vga_ctrl u_big (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd_b), .pix_x(px_b), .pix_y(py_b),
    .frame_end(fe_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b));

  vga_ctrl #(.H_SYNC(SH_S), .H_BACK(SH_B), .H_VALID(SH_V), .H_FRONT(SH_F),
             .V_SYNC(SV_S), .V_BACK(SV_B), .V_VALID(SV_V), .V_FRONT(SV_F),
             .SYNC_POL(1'b0), .PIX_LAT(0)) u_s0 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd_0), .pix_x(px_0), .pix_y(py_0),
    .frame_end(fe_0), .hsync(hs_0), .vsync(vs_0), .rgb(rgb_0));

  vga_ctrl #(.H_SYNC(SH_S), .H_BACK(SH_B), .H_VALID(SH_V), .H_FRONT(SH_F),
             .V_SYNC(SV_S), .V_BACK(SV_B), .V_VALID(SV_V), .V_FRONT(SV_F),
             .SYNC_POL(1'b0), .PIX_LAT(1)) u_s1 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd_1), .pix_x(px_1), .pix_y(py_1),
    .frame_end(fe_1), .hsync(hs_1), .vsync(vs_1), .rgb(rgb_1));

  vga_ctrl #(.H_SYNC(SH_S), .H_BACK(SH_B), .H_VALID(SH_V), .H_FRONT(SH_F),
             .V_SYNC(SV_S), .V_BACK(SV_B), .V_VALID(SV_V), .V_FRONT(SV_F),
             .SYNC_POL(1'b1), .PIX_LAT(3)) u_s3 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd_3), .pix_x(px_3), .pix_y(py_3),
    .frame_end(fe_3), .hsync(hs_3), .vsync(vs_3), .rgb(rgb_3));

  // ---------------- timeline model ----------------
  // Screen position at time tt is (tt mod line, line mod frame). Pins show
  // the position lat+1 cycles earlier; before that they sit idle.
  function automatic obs_t model(input int hsw, input int hb, input int hv, input int hf,
                                 input int vsw, input int vb, input int vv, input int vf,
                                 input bit pol, input int lat, input int tt);
    obs_t o;
    int ht = hsw + hb + hv + hf;
    int vt = vsw + vb + vv + vf;
    int h, v, p;
    h = tt % ht;
    v = (tt / ht) % vt;
    if (h >= hsw + hb && h < hsw + hb + hv && v >= vsw + vb && v < vsw + vb + vv) begin
      o.x = 10'(h - hsw - hb);
      o.y = 10'(v - vsw - vb);
    end else begin
      o.x = 10'h3FF;
      o.y = 10'h3FF;
    end
    o.fe = (h == ht - 1) && (v == vt - 1);
    p = tt - lat - 1;
    if (p < 0) begin
      o.hs  = ~pol;
      o.vs  = ~pol;
      o.rgb = 16'h0000;
    end else begin
      h = p % ht;
      v = (p / ht) % vt;
      o.hs = (h < hsw) ? pol : ~pol;
      o.vs = (v < vsw) ? pol : ~pol;
      if (h >= hsw + hb && h < hsw + hb + hv && v >= vsw + vb && v < vsw + vb + vv)
        o.rgb = {6'(h - hsw - hb), 10'(v - vsw - vb)};
      else
        o.rgb = 16'h0000;
    end
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s t=%0d got x=%h y=%h fe=%b hs=%b vs=%b rgb=%h want x=%h y=%h fe=%b hs=%b vs=%b rgb=%h",
                 nm, t, act.x, act.y, act.fe, act.hs, act.vs, act.rgb,
                 exp.x, exp.y, exp.fe, exp.hs, exp.vs, exp.rgb);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0d (0x%0h) want %0d (0x%0h)", nm, t, act, act, exp, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    chk_obs("big", '{px_b, py_b, fe_b, hs_b, vs_b, rgb_b},
            model(96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1, t));
    chk_obs("s_lat0", '{px_0, py_0, fe_0, hs_0, vs_0, rgb_0},
            model(SH_S, SH_B, SH_V, SH_F, SV_S, SV_B, SV_V, SV_F, 1'b0, 0, t));
    chk_obs("s_lat1", '{px_1, py_1, fe_1, hs_1, vs_1, rgb_1},
            model(SH_S, SH_B, SH_V, SH_F, SV_S, SV_B, SV_V, SV_F, 1'b0, 1, t));
    chk_obs("s_lat3", '{px_3, py_3, fe_3, hs_3, vs_3, rgb_3},
            model(SH_S, SH_B, SH_V, SH_F, SV_S, SV_B, SV_V, SV_F, 1'b1, 3, t));
  end

  // ---------------- pulse width / period trackers ----------------
  int  hb_fall = -1, hb_rise = -1, vb_fall = -1;
  int  v1_fall = -1, v1_rise = -1, fe1_last = -1;
  logic hs_b_prev = 1'b1, vs_b_prev = 1'b1, vs_1_prev = 1'b1, fe_1_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hb_fall = -1; hb_rise = -1; vb_fall = -1;
      v1_fall = -1; v1_rise = -1; fe1_last = -1;
      hs_b_prev = 1'b1; vs_b_prev = 1'b1; vs_1_prev = 1'b1; fe_1_prev = 1'b0;
    end else begin
      if (hs_b_prev && !hs_b) hb_fall = t;
      if (!hs_b_prev && hs_b) begin
        if (hb_fall >= 0) chk_val("hsync_low_len", t - hb_fall, 96);
        if (hb_rise >= 0) chk_val("hsync_period", t - hb_rise, 800);
        hb_rise = t;
      end
      if (vs_b_prev && !vs_b) vb_fall = t;
      if (!vs_b_prev && vs_b && vb_fall >= 0) chk_val("vsync_low_len_big", t - vb_fall, 1600);

      if (vs_1_prev && !vs_1) v1_fall = t;
      if (!vs_1_prev && vs_1) begin
        if (v1_fall >= 0) chk_val("vsync_low_len_s", t - v1_fall, SV_S * S_HT);
        if (v1_rise >= 0) chk_val("vsync_period_s", t - v1_rise, S_FRAME);
        v1_rise = t;
      end
      if (fe_1) begin
        if (fe_1_prev) chk_val("frame_end_width", 2, 1);
        else if (fe1_last >= 0) chk_val("frame_end_period", t - fe1_last, S_FRAME);
        fe1_last = t;
      end
      hs_b_prev = hs_b; vs_b_prev = vs_b; vs_1_prev = vs_1; fe_1_prev = fe_1;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic wait_t(input int n);
    int g = 0;
    while (t != n && g < 70000) begin
      @(negedge clk);
      g++;
    end
    if (t != n) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_t got t=%0d want %0d", t, n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk_val("rst_hsync", int'(hs_b), 1);
    chk_val("rst_vsync", int'(vs_b), 1);
    chk_val("rst_rgb",   int'(rgb_b), 0);
    chk_val("rst_pix_x", int'(px_b), 10'h3FF);
    chk_val("rst_pix_y", int'(py_b), 10'h3FF);
    @(posedge clk); #2 rst_n = 1'b1;

    // Small timing: first visible at (7,5) -> t=92; last (14,9) -> t=167.
    wait_t(92);  chk_val("s_first_x", int'(px_1), 0);
                 chk_val("s_first_y", int'(py_1), 0);
    wait_t(167); chk_val("s_last_x", int'(px_1), 7);
                 chk_val("s_last_y", int'(py_1), 4);
    wait_t(168); chk_val("s0_last_rgb", int'(rgb_0), 16'h1C04);
    wait_t(169); chk_val("s1_last_rgb", int'(rgb_1), 16'h1C04);
    wait_t(171); chk_val("s3_last_rgb", int'(rgb_3), 16'h1C04);

    // Default timing: first visible line is 35 (t base 28000).
    wait_t(27999); chk_val("big_y_before", int'(py_b), 10'h3FF);
    wait_t(28143); chk_val("big_x_143", int'(px_b), 10'h3FF);
    wait_t(28144); chk_val("big_x_144", int'(px_b), 0);
                   chk_val("big_y_144", int'(py_b), 0);
    wait_t(28147); chk_val("big_rgb_x1", int'(rgb_b), 16'h0400);
    wait_t(28783); chk_val("big_x_783", int'(px_b), 639);
    wait_t(28784); chk_val("big_x_784", int'(px_b), 10'h3FF);
    wait_t(28785); chk_val("big_rgb_x639", int'(rgb_b), 16'hFC00);

    // Mid-line reset at cnt_h=400 on line 36 (pixel x=256, y=1).
    wait_t(29200); chk_val("pre_rst_x", int'(px_b), 256);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk_val("async_rst_x",   int'(px_b), 10'h3FF);
    chk_val("async_rst_rgb", int'(rgb_b), 0);
    chk_val("async_rst_hs3", int'(hs_3), 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;

    // Restarted timing: model and trackers cover 2+ lines and 8 small frames.
    wait_t(1);   chk_val("restart_hs", int'(hs_b), 1);
    wait_t(2);   chk_val("restart_hs_active", int'(hs_b), 0);
    wait_t(1700);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
